// File: rtl/gshare_bpu_if.sv
// gshare_bpu_if: signal bundle between the fetch/EX pipeline and the gshare predictor
//   master: pipeline side (drives lookup pc/stall, BTB invalidate and EX resolve)
//   slave : predictor side (returns pred_valid/pred_npc/pred_ghr and ready)
interface gshare_bpu_if #(parameter int GHR_LEN = 8);
  logic               is_stall;
  logic [31:0]        pc;
  logic               pred_valid;
  logic [31:0]        pred_npc;
  logic [GHR_LEN-1:0] pred_ghr;
  logic               ready;
  logic               btb_inv_valid;
  logic [31:0]        btb_inv_pc;
  logic               res_valid;
  logic [31:0]        res_pc;
  logic               res_taken;
  logic [31:0]        res_target;
  logic [GHR_LEN-1:0] res_ghr;
  logic               res_mispredict;
  modport master (
    output is_stall, pc, btb_inv_valid, btb_inv_pc,
           res_valid, res_pc, res_taken, res_target, res_ghr, res_mispredict,
    input  pred_valid, pred_npc, pred_ghr, ready
  );
  modport slave (
    input  is_stall, pc, btb_inv_valid, btb_inv_pc,
           res_valid, res_pc, res_taken, res_target, res_ghr, res_mispredict,
    output pred_valid, pred_npc, pred_ghr, ready
  );
endinterface

// File: rtl/gshare_bpu.sv
// gshare_bpu: gshare direction predictor (PC ^ GHR indexed 2-bit PHT) plus direct-mapped BTB
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gshare_bpu_if.slave (fetch1 lookup, fetch2 invalidate, EX resolve)
//   stat_lookup, stat_mispred : event counters, present only with BPU_STATS_EN defined
module gshare_bpu #(
  parameter int GHR_LEN        = 8,
  parameter int PHT_IDX_W      = 10,
  parameter int BTB_IDX_W      = 6,
  parameter int BTB_TAG_W      = 12,
  parameter int INST_ALIGN_WID = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  gshare_bpu_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_lookup,
  output logic [31:0] stat_mispred
`endif
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_LSB = INST_ALIGN_WID + BTB_IDX_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t               r_state, w_state_nxt;
  logic [PHT_IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]           r_pht [PHT_N];
  logic [BTB_N-1:0]     r_btb_v;
  logic [BTB_TAG_W-1:0] r_btb_tag [BTB_N];
  logic [31:0]          r_btb_tgt [BTB_N];
  logic [GHR_LEN-1:0]   r_ghr, w_ghr_nxt;
  logic                 r_pred_valid;
  logic [31:0]          r_pred_npc;
  logic [GHR_LEN-1:0]   r_pred_ghr;
  logic                 r_u2_v, r_u2_taken;
  logic [PHT_IDX_W-1:0] r_u2_idx;
  logic [1:0]           r_u2_cnt;
  logic                 w_run, w_look, w_hit, w_dir, w_upd, w_btb_we, w_inv;
  logic [PHT_IDX_W-1:0] w_idx, w_uidx;
  logic [BTB_IDX_W-1:0] w_bidx, w_widx, w_iidx;
  logic [1:0]           w_u2_new, w_ucnt;
  logic [GHR_LEN:0]     w_rep, w_shf;
  logic                 w_unused;
  always_comb begin
    w_run       = r_state == RUN;
    w_state_nxt = (!w_run && &r_cnt) ? RUN : r_state;
    w_cnt_nxt   = w_run ? r_cnt : r_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  always_comb begin
    w_idx    = bus.pc[INST_ALIGN_WID +: PHT_IDX_W] ^ PHT_IDX_W'(r_ghr);
    w_bidx   = bus.pc[INST_ALIGN_WID +: BTB_IDX_W];
    w_hit    = r_btb_v[w_bidx] && r_btb_tag[w_bidx] == bus.pc[TAG_LSB +: BTB_TAG_W];
    w_dir    = r_pht[w_idx][1];
    w_look   = w_run && !bus.is_stall;
    w_rep    = {bus.res_ghr, bus.res_taken};
    w_shf    = {r_ghr, w_dir};
    w_ghr_nxt = !w_look ? r_ghr :
                bus.res_mispredict ? w_rep[GHR_LEN-1:0] :
                w_hit ? w_shf[GHR_LEN-1:0] : r_ghr;
    w_upd    = w_run && bus.res_valid;
    w_uidx   = bus.res_pc[INST_ALIGN_WID +: PHT_IDX_W] ^ PHT_IDX_W'(bus.res_ghr);
    w_u2_new = r_u2_taken ? (r_u2_cnt == 2'd3 ? 2'd3 : r_u2_cnt + 2'd1)
                          : (r_u2_cnt == 2'd0 ? 2'd0 : r_u2_cnt - 2'd1);
    // an update still sitting in U2 for the same entry supplies the counter, so
    // back-to-back resolves of one branch accumulate instead of overwriting
    w_ucnt   = (r_u2_v && r_u2_idx == w_uidx) ? w_u2_new : r_pht[w_uidx];
    w_widx   = bus.res_pc[INST_ALIGN_WID +: BTB_IDX_W];
    w_btb_we = w_run && bus.res_valid && bus.res_taken;
    w_iidx   = bus.btb_inv_pc[INST_ALIGN_WID +: BTB_IDX_W];
    w_inv    = bus.btb_inv_valid && r_btb_v[w_iidx] &&
               r_btb_tag[w_iidx] == bus.btb_inv_pc[TAG_LSB +: BTB_TAG_W];
    w_unused = ^{bus.pc, bus.res_pc, bus.btb_inv_pc, w_rep, w_shf};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_npc   <= '0;
      r_pred_ghr   <= '0;
      r_u2_v       <= 1'b0;
      r_u2_taken   <= 1'b0;
      r_u2_idx     <= '0;
      r_u2_cnt     <= '0;
    end else begin
      r_ghr <= w_ghr_nxt;
      if (!bus.is_stall) begin
        r_pred_valid <= w_run && w_hit && w_dir;
        r_pred_npc   <= r_btb_tgt[w_bidx];
        r_pred_ghr   <= r_ghr;
      end
      r_u2_v     <= w_upd;
      r_u2_taken <= bus.res_taken;
      r_u2_idx   <= w_uidx;
      r_u2_cnt   <= w_ucnt;
    end
  // single PHT write port: the init sweep owns it until RUN, then U2
  always_ff @(posedge clk)
    if (!w_run) r_pht[r_cnt] <= 2'b01;
    else if (r_u2_v) r_pht[r_u2_idx] <= w_u2_new;
  // write is applied after invalidate so an allocation to the same entry wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_btb_v <= '0;
    else begin
      if (w_inv) r_btb_v[w_iidx] <= 1'b0;
      if (w_btb_we) r_btb_v[w_widx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (w_btb_we) begin
      r_btb_tag[w_widx] <= bus.res_pc[TAG_LSB +: BTB_TAG_W];
      r_btb_tgt[w_widx] <= bus.res_target;
    end
`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_lookup  <= '0;
      stat_mispred <= '0;
    end else begin
      if (w_look) stat_lookup <= stat_lookup + 32'd1;
      if (bus.res_valid && bus.res_mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
`endif
  assign bus.pred_valid = r_pred_valid;
  assign bus.pred_npc   = r_pred_npc;
  assign bus.pred_ghr   = r_pred_ghr;
  assign bus.ready      = w_run;
endmodule

// File: doc/gshare_bpu.md
Name: gshare_bpu

Overview:
- Parametrised gshare branch predictor for fetch stage 1: a direct-mapped BTB plus a 2-bit-counter PHT indexed by PC XOR global history.
- Generalises the previous predictor with configurable history, PHT and BTB sizes.
- Adds: a speculative GHR with mispredict repair, a pipelined PHT read-modify-write with forwarding, and a post-reset PHT initialisation sweep FSM.
- Lookup in fetch1; prediction registered for fetch2; trained from EX.

Parameters:
- GHR_LEN, 8, global history bits; must satisfy GHR_LEN <= PHT_IDX_W.
- PHT_IDX_W, 10, log2 of PHT entries.
- BTB_IDX_W, 6, log2 of BTB entries.
- BTB_TAG_W, 12, BTB tag bits taken from pc above the index.
- INST_ALIGN_WID, 2, low pc bits ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- is_stall  in  1  fetch1 stall; hold prediction outputs and spec GHR
- pc  in  32  fetch1 lookup PC
- pred_valid  out  1  predicted taken, redirect to pred_npc
- pred_npc  out  32  predicted target
- pred_ghr  out  GHR_LEN  spec GHR used for this lookup; carried down the pipe to EX
- ready  out  1  PHT init done
- btb_inv_valid  in  1  fetch2 invalidate request
- btb_inv_pc  in  32  PC whose BTB entry is cleared
- res_valid  in  1  EX resolved a conditional branch
- res_pc  in  32  branch PC
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- res_ghr  in  GHR_LEN  pred_ghr that travelled with this branch
- res_mispredict  in  1  EX redirect; repair GHR

Behaviour:
- Reset: async on rst_n low.
  - pred_valid=0, pred_npc=0, pred_ghr=0, ready=0, spec GHR=0.
  - All BTB valid bits cleared. FSM enters INIT with sweep counter 0.
  - Reset mid-sweep or mid-run restarts INIT from index 0.
- FSM INIT:
  - Each cycle writes PHT[cnt]=2'b01 (weakly not-taken), then cnt++.
  - After writing index 2^PHT_IDX_W-1, go to RUN; ready=1 the following cycle.
  - INIT lasts exactly 2^PHT_IDX_W cycles.
  - In INIT: pred_valid=0, all res_* updates and BTB writes are dropped, btb_inv is honoured.
- FSM RUN: no exit except reset.
- Lookup latency: 1 cycle.
  - Inputs: pc and spec GHR at cycle t. Outputs valid at t+1.
  - idx = pc[INST_ALIGN_WID +: PHT_IDX_W] XOR zero-extended spec GHR.
  - BTB hit = valid && tag match on pc[INST_ALIGN_WID+BTB_IDX_W +: BTB_TAG_W].
  - pred_valid = hit && PHT[idx] >= 2. pred_npc = BTB target. pred_ghr = spec GHR at t.
  - If is_stall at t: outputs and spec GHR hold.
- Spec GHR, RUN and not stalled:
  - On BTB hit, shift left, LSB = predicted direction.
  - On miss, unchanged.
  - res_mispredict has priority: spec GHR <= {res_ghr[GHR_LEN-2:0], res_taken}. Same cycle as a lookup, the repair wins.
- PHT update, 2-stage:
  - U1 (res_valid): compute uidx = res_pc index XOR res_ghr, read counter.
  - U2: saturating inc if taken (max 3), dec if not (min 0), then write.
  - Back-to-back updates to the same uidx forward the U2 result into U1; no lost increments.
  - A lookup reading uidx in the U2 write cycle sees the old value (no write-to-read bypass).
- BTB write, same cycle as res_valid && res_taken: entry[res_pc idx] <= {valid=1, tag, res_target}. Not-taken never allocates.
- BTB invalidate: btb_inv_valid clears the valid bit only if the tag matches.
  - Same cycle and same index as a BTB write: the write wins.
- Width rules: counters 2-bit unsigned saturating; GHR shift drops the MSB.

Optional Feature:
- Macro BPU_STATS_EN.
- Defined: adds outputs stat_lookup[31:0] and stat_mispred[31:0].
  - stat_lookup increments on each non-stalled RUN lookup.
  - stat_mispred increments on res_valid && res_mispredict.
  - Both are async-reset to 0 and wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Release rst_n with PHT_IDX_W=4 -> ready=0 for 16 cycles, ready=1 at cycle 17; any res_valid during INIT leaves BTB empty (subsequent pred_valid=0).
- res_valid taken for pc=0x1C000010, target=0x1C000100, res_ghr=0, twice -> counter 01->10->11; with GHR=0, lookup of 0x1C000010 gives pred_valid=1, pred_npc=0x1C000100 next cycle.
- Same branch resolved taken in two consecutive cycles from counter 01 -> counter=11, not 10 (forwarding).
- Spec GHR=0x0F, res_mispredict with res_ghr=0x03, res_taken=0 -> next pred_ghr=0x06.
- Trained entry, then btb_inv_pc with matching tag -> pred_valid=0; non-matching tag -> entry kept.
- is_stall=1 for 3 cycles with pc changing -> pred_valid, pred_npc and pred_ghr held constant.
